// File: rtl/drygascon128_seq_pkg.sv
// Shared types and field widths for the drygascon128 command sequencer.
package drygascon128_seq_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DS_W     = 4;
    localparam int unsigned ROUNDS_W = 4;
    localparam int unsigned LEN_W    = 4;

    typedef enum logic [2:0] {
        OP_WR_C  = 3'd0,
        OP_WR_X  = 3'd1,
        OP_WR_I  = 3'd2,
        OP_START = 3'd3,
        OP_RD_R  = 3'd4,
        OP_RD_C  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StWaitc,
        StWrite,
        StStart,
        StRun,
        StRdreq,
        StRdwait,
        StRdout
    } state_e;

    function automatic logic op_is_write(op_e op);
        return (op == OP_WR_C) || (op == OP_WR_X) || (op == OP_WR_I);
    endfunction

endpackage

// File: rtl/drygascon128_seq.sv
// Command sequencer turning a valid/ready command stream into drygascon128 core strobes.
// Optional RUN watchdog enabled by defining DRYGASCON128_SEQ_TIMEOUT_EN.
module drygascon128_seq
    import drygascon128_seq_pkg::*;
#(
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DS_W-1:0]     cmd_ds,
    input  logic [ROUNDS_W-1:0] cmd_rounds,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [WORD_W-1:0]   wdata,
    output logic                rdata_valid,
    input  logic                rdata_ready,
    output logic [WORD_W-1:0]   rdata,
    output logic                rdata_last,
    output logic                busy,
    output logic                err,
    output logic [WORD_W-1:0]   core_din,
    output logic [DS_W-1:0]     core_ds,
    output logic [ROUNDS_W-1:0] core_rounds,
    output logic                core_wr_i,
    output logic                core_wr_c,
    output logic                core_wr_x,
    output logic                core_start,
    output logic                core_rd_r,
    output logic                core_rd_c,
    input  logic [WORD_W-1:0]   core_dout,
    input  logic                core_idle
);

    localparam logic [1:0] LatLast = 2'(RD_LAT - 1);

    state_e               state_q;
    op_e                  op_q;
    logic [LEN_W-1:0]     len_q;
    logic [DS_W-1:0]      ds_q;
    logic [ROUNDS_W-1:0]  rounds_q;
    logic                 cmd_ready_q, wdata_ready_q, rdata_valid_q, rdata_last_q, err_q;
    logic [WORD_W-1:0]    core_din_q, rdata_q;
    logic [DS_W-1:0]      core_ds_q;
    logic [ROUNDS_W-1:0]  core_rounds_q;
    logic                 wr_i_q, wr_c_q, wr_x_q, start_q, rd_r_q, rd_c_q;
    logic [1:0]           lat_q;
    logic                 run_first_q;

`ifdef DRYGASCON128_SEQ_TIMEOUT_EN
    localparam logic [9:0] ToLast = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] to_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= OP_WR_C;
            len_q         <= '0;
            ds_q          <= '0;
            rounds_q      <= '0;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            err_q         <= 1'b0;
            core_din_q    <= '0;
            rdata_q       <= '0;
            core_ds_q     <= '0;
            core_rounds_q <= '0;
            wr_i_q        <= 1'b0;
            wr_c_q        <= 1'b0;
            wr_x_q        <= 1'b0;
            start_q       <= 1'b0;
            rd_r_q        <= 1'b0;
            rd_c_q        <= 1'b0;
            lat_q         <= '0;
            run_first_q   <= 1'b0;
`ifdef DRYGASCON128_SEQ_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below.
            wr_i_q  <= 1'b0;
            wr_c_q  <= 1'b0;
            wr_x_q  <= 1'b0;
            start_q <= 1'b0;
            rd_r_q  <= 1'b0;
            rd_c_q  <= 1'b0;

            case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_op > 3'd5) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q        <= op_e'(cmd_op);
                            len_q       <= cmd_len;
                            ds_q        <= cmd_ds;
                            rounds_q    <= cmd_rounds;
                            cmd_ready_q <= 1'b0;
                            state_q     <= StWaitc;
                        end
                    end
                end
                StWaitc: begin
                    if (core_idle) begin
                        if (op_q == OP_START) begin
                            core_ds_q     <= ds_q;
                            core_rounds_q <= rounds_q;
                            state_q       <= StStart;
                        end else if (len_q == '0) begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else if (op_is_write(op_q)) begin
                            wdata_ready_q <= 1'b1;
                            state_q       <= StWrite;
                        end else begin
                            // The read strobe is high for the whole RDREQ cycle.
                            rd_c_q  <= (op_q == OP_RD_C);
                            rd_r_q  <= (op_q != OP_RD_C);
                            state_q <= StRdreq;
                        end
                    end
                end
                StWrite: begin
                    if (wdata_ready_q) begin
                        if (wdata_valid) begin
                            core_din_q <= wdata;
                            case (op_q)
                                OP_WR_C: wr_c_q <= 1'b1;
                                OP_WR_X: wr_x_q <= 1'b1;
                                default: wr_i_q <= 1'b1;
                            endcase
                            len_q <= len_q - 4'd1;
                            if (len_q == 4'd1) wdata_ready_q <= 1'b0;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StStart: begin
                    start_q     <= 1'b1;
                    run_first_q <= 1'b1;
                    state_q     <= StRun;
`ifdef DRYGASCON128_SEQ_TIMEOUT_EN
                    to_cnt_q    <= '0;
`endif
                end
                StRun: begin
                    run_first_q <= 1'b0;
                    // core_idle still reflects the pre-start state in the first cycle.
                    if (!run_first_q) begin
                        if (core_idle) begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end
`ifdef DRYGASCON128_SEQ_TIMEOUT_EN
                        else if (to_cnt_q == ToLast) begin
                            err_q       <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            to_cnt_q <= to_cnt_q + 10'd1;
                        end
`endif
                    end
                end
                StRdreq: begin
                    lat_q   <= '0;
                    state_q <= StRdwait;
                end
                StRdwait: begin
                    if (lat_q == LatLast) begin
                        rdata_q       <= core_dout;
                        rdata_valid_q <= 1'b1;
                        rdata_last_q  <= (len_q == 4'd1);
                        state_q       <= StRdout;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                StRdout: begin
                    if (rdata_ready) begin
                        rdata_valid_q <= 1'b0;
                        rdata_last_q  <= 1'b0;
                        len_q         <= len_q - 4'd1;
                        if (len_q == 4'd1) begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            rd_c_q  <= (op_q == OP_RD_C);
                            rd_r_q  <= (op_q != OP_RD_C);
                            state_q <= StRdreq;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q != StIdle);
    assign err         = err_q;
    assign core_din    = core_din_q;
    assign core_ds     = core_ds_q;
    assign core_rounds = core_rounds_q;
    assign core_wr_i   = wr_i_q;
    assign core_wr_c   = wr_c_q;
    assign core_wr_x   = wr_x_q;
    assign core_start  = start_q;
    assign core_rd_r   = rd_r_q;
    assign core_rd_c   = rd_c_q;

    strobe_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({wr_i_q, wr_c_q, wr_x_q, start_q, rd_r_q, rd_c_q}));

endmodule
